sda_tx_arbiter: RTL and testbench

SDA_TX_ARBITER -- requirements
Module: sda_tx_arbiter

---
 rtl/sda_tx_arbiter_if.sv | 24 ++
 rtl/sda_tx_arbiter.sv | 108 ++++++++++
 tb/tb_sda_tx_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sda_tx_arbiter_if.sv
// Requester/transmitter bus of the SDA transmit arbiter.
// The slave modport is the arbiter; master is the requesters and transmitter side.
interface sda_tx_arbiter_if;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic [3:0]  tx_data;
  logic        tx_go;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    output req, req_data, tx_busy, tx_done,
    input  gnt, done, err, busy, tx_data, tx_go
  );

  modport slave (
    input  req, req_data, tx_busy, tx_done,
    output gnt, done, err, busy, tx_data, tx_go
  );
endinterface

// File: rtl/sda_tx_arbiter.sv
// Round-robin arbiter that grants one of four requesters the serial transmitter,
// launches its nibble and waits for frame completion or a timeout abort.
module sda_tx_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              sclk,
  input  logic              rst,
  sda_tx_arbiter_if.slave   bus
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RELEASE} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic               err_q;
  logic               busy_q;
  logic [DATA_W-1:0]  tx_data_q;
  logic               tx_go_q;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win;

  logic [IDX_W-1:0]   win_c;
  logic               found_c;
  logic [IDX_W-1:0]   cand_c;

  // Round-robin search starting one past the last winner.
  always_comb begin
    win_c   = '0;
    found_c = 1'b0;
    cand_c  = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand_c = IDX_W'(32'(ptr) + k);
      if (!found_c && bus.req[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_data_q <= '0;
      tx_go_q   <= 1'b0;
      cnt       <= '0;
      ptr       <= IDX_W'(NUM_REQ - 1);
      win       <= '0;
    end else begin
      case (state)
        IDLE: begin
          gnt_q <= '0;
          if (found_c && !bus.tx_busy) begin
            win       <= win_c;
            gnt_q     <= NUM_REQ'(1) << win_c;
            tx_data_q <= bus.req_data[{win_c, 2'b00} +: DATA_W];
            tx_go_q   <= 1'b1;
            busy_q    <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_go_q <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // A completing frame beats a coincident timeout.
          if (bus.tx_done) begin
            done_q <= NUM_REQ'(1) << win;
            state  <= RELEASE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          ptr    <= win;
          gnt_q  <= '0;
          done_q <= '0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_go   = tx_go_q;

endmodule

// File: tb/tb_sda_tx_arbiter.sv
// Self-checking bench for sda_tx_arbiter: vector table driven through a
// scoreboard queue, plus blocking and mid-transfer reset sequences.
module tb_sda_tx_arbiter;

  logic sclk;
  logic rst;
  sda_tx_arbiter_if bif ();

  sda_tx_arbiter #(.TIMEOUT(8)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bif.slave)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  typedef struct {
    logic [3:0]  req;
    logic [15:0] data;
    int          dly;   // WAIT cycle (1-based) carrying tx_done; 0 = never
    logic [3:0]  gnt;
    logic [3:0]  tdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] tdata;
    logic       err;
    int         dly;
  } exp_t;

  int   total;
  int   bad;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    exp_t e;
    int   lat;
    int   pulse_c;
    int   go_cnt;
    int   want_c;
    exp_q.push_back('{v.gnt, v.tdata, v.err, v.dly});
    bif.req      = v.req;
    bif.req_data = v.data;
    bif.tx_done  = 1'b0;
    lat = 0;
    do begin
      @(negedge sclk);
      lat++;
    end while (!bif.tx_go && lat < 10);
    chk("go_latency", 32'(lat), 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("gnt", 32'(bif.gnt), 32'(e.gnt));
    chk("tx_data", 32'(bif.tx_data), 32'(e.tdata));
    chk("busy_launch", 32'(bif.busy), 32'd1);
    // Requests changing mid-transfer must not disturb it.
    bif.req      = 4'($urandom);
    bif.req_data = 16'($urandom);
    pulse_c = 0;
    go_cnt  = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge sclk);
      if (bif.tx_go) go_cnt++;
      bif.tx_done = (c == e.dly);
      if (bif.done != 4'h0 || bif.err) begin
        pulse_c = c;
        break;
      end
    end
    want_c = (e.dly >= 1 && e.dly <= 8) ? e.dly + 1 : 9;
    chk("pulse_cycle", 32'(pulse_c), 32'(want_c));
    chk("done", 32'(bif.done), e.err ? 32'd0 : 32'(e.gnt));
    chk("err", 32'(bif.err), 32'(e.err));
    chk("gnt_hold", 32'(bif.gnt), 32'(e.gnt));
    chk("tx_data_hold", 32'(bif.tx_data), 32'(e.tdata));
    chk("single_go", 32'(go_cnt), 32'd0);
    bif.req = 4'h0;
    @(negedge sclk);
    bif.tx_done = 1'b0;
    chk("idle_after", 32'({bif.gnt, bif.busy, bif.done, bif.err}), 32'd0);
  endtask

  vec_t tbl[11];
  int   lat;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    tbl[0]  = '{4'b1111, 16'hDCBA, 3, 4'b0001, 4'hA, 1'b0};
    tbl[1]  = '{4'b1111, 16'hDCBA, 2, 4'b0010, 4'hB, 1'b0};
    tbl[2]  = '{4'b1111, 16'hDCBA, 4, 4'b0100, 4'hC, 1'b0};
    tbl[3]  = '{4'b1111, 16'hDCBA, 6, 4'b1000, 4'hD, 1'b0};
    tbl[4]  = '{4'b1111, 16'hDCBA, 1, 4'b0001, 4'hA, 1'b0};
    tbl[5]  = '{4'b0100, 16'h0A00, 5, 4'b0100, 4'hA, 1'b0};
    tbl[6]  = '{4'b0010, 16'h00F0, 0, 4'b0010, 4'hF, 1'b1};
    tbl[7]  = '{4'b1010, 16'h5000, 8, 4'b1000, 4'h5, 1'b0};
    tbl[8]  = '{4'b1001, 16'h900E, 9, 4'b0001, 4'hE, 1'b1};
    tbl[9]  = '{4'b0110, 16'h0C70, 1, 4'b0010, 4'h7, 1'b0};
    tbl[10] = '{4'b0001, 16'h0003, 3, 4'b0001, 4'h3, 1'b0};

    bif.req = 4'h0; bif.req_data = 16'h0; bif.tx_busy = 1'b0; bif.tx_done = 1'b0;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(negedge sclk);
    chk("reset_outputs", 32'({bif.gnt, bif.done, bif.err, bif.tx_go, bif.busy, bif.tx_data}), 32'd0);
    rst = 1'b1;
    @(negedge sclk);

    for (int i = 0; i < 11; i++) run_xfer(tbl[i]);

    // Transmitter busy blocks arbitration; dropping it grants on the next edge.
    bif.tx_busy = 1'b1;
    bif.req     = 4'b0001;
    bif.req_data = 16'h0006;
    lat = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge sclk);
      if (bif.tx_go || bif.gnt != 4'h0 || bif.busy) lat++;
    end
    chk("blocked_no_grant", 32'(lat), 32'd0);
    bif.tx_busy = 1'b0;
    run_xfer('{4'b0001, 16'h0006, 2, 4'b0001, 4'h6, 1'b0});

    // Reset mid-WAIT aborts silently and restores the pointer to 3.
    bif.req = 4'b0100;
    bif.req_data = 16'h0800;
    lat = 0;
    do begin
      @(negedge sclk);
      lat++;
    end while (!bif.tx_go && lat < 10);
    chk("rst_case_go", 32'({bif.tx_go, bif.gnt}), 32'({1'b1, 4'b0100}));
    bif.req = 4'h0;
    repeat (3) @(negedge sclk);
    chk("mid_wait_busy", 32'(bif.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_async_clear", 32'({bif.gnt, bif.done, bif.err, bif.tx_go, bif.busy, bif.tx_data}), 32'd0);
    @(negedge sclk);
    chk("rst_no_pulse", 32'({bif.done, bif.err}), 32'd0);
    rst = 1'b1;
    run_xfer('{4'b0011, 16'h0021, 3, 4'b0001, 4'h1, 1'b0});
    run_xfer('{4'b0010, 16'h00B0, 2, 4'b0010, 4'hB, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
